id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
// ID/EX pipeline register plus load-use hazard unit; sits directly downstream of the opcode decoder.
// Captures decoder control bits, register operands, immediate and PC at the end of ID and presents them to EX.
// Inserts a bubble on load-use hazard or branch/jump flush, freezes PC and IF/ID while stalling,
// and counts the bubbles it inserts.
// PARAMETERS
// XLEN   32  datapath width (PC, operands, immediate)
// CNT_W  16  width of bubble counter
// PORTS
// clk           in   1     clock, rising edge
// reset         in   1     synchronous, active-high
// flush_i       in   1     EX resolved taken branch/JAL/JALR; kill ID instruction
// opcode_i      in   7     ID opcode (same field driven into the decoder)
// alusrc_i      in   1     decoder ALUSrc
// mem2reg_i     in   2     decoder Mem2Reg
// regwrite_i    in   1     decoder RegWrite
// memread_i     in   1     decoder MemRead
// memwrite_i    in   1     decoder MemWrite
// branch_i      in   2     decoder Branch (2'b00 = no branch)
// aluop_i       in   2     decoder ALUOp
// pc_i          in   XLEN  ID PC
// rs1_data_i    in   XLEN  register file port A
// rs2_data_i    in   XLEN  register file port B
// imm_i         in   XLEN  sign-extended immediate
// rs1_i,rs2_i,rd_i in 5    register indices
// funct_i       in   4     {funct7[5], funct3}
// *_o (one per registered input above, same width) out  EX-side copies
// pc_write_o    out  1     0 = hold PC
// ifid_write_o  out  1     0 = hold IF/ID
// bubble_cnt_o  out  CNT_W bubbles inserted since reset
// BEHAVIOUR
// - Reset: every *_o = 0, pc_write_o = ifid_write_o = 1, bubble_cnt_o = 0. Reset overrides everything.
// - Latency: 1 cycle; inputs sampled on rising clk, visible on *_o next cycle.
// - hazard = memread_o & (rd_o != 0) & ((rd_o == rs1_i) | (rd_o == rs2_i)).
// - Rs2 match counts for every opcode (conservative; no opcode qualification).
// - stall = hazard & ~flush_i.
// - pc_write_o = ifid_write_o = ~stall (combinational, same cycle).
// - Priority per edge: reset > flush_i > stall > normal capture.
// - flush_i or stall: control outputs (alusrc, mem2reg, regwrite, memread, memwrite, branch, aluop) load 0.
// - Bubble datapath fields (pc, data, imm, rs1/rs2/rd, funct) load 0.
// - Normal: all outputs load their inputs.
// - Illegal-opcode sanitising: opcode_i outside {0110011, 0000011, 0100011, 1100011, 0010011, 1100111, 1101111}
//   is captured as a bubble (controls 0, never X); regwrite/memwrite never X in EX.
// - Defined don't-cares: X/Z on any control input of a legal opcode loads 0.
// - Counter: +1 on every clock where flush_i or stall inserts a bubble; saturates at all-ones (no wrap).
// - Flush and hazard same cycle: single bubble, counted once; no stall, so upstream drops the IF/ID instruction.
// - Back-to-back hazard cannot persist: bubble clears memread_o, so stall lasts exactly 1 cycle.
// - Reset mid-stall: next cycle stall released, pipe empty.
// CONFIGURATION
// ID_EX_ILLEGAL_TRAP_EN defined:
//   - adds output illegal_o (1 bit, reset 0).
//   - Sets sticky 1 on the edge an illegal opcode is captured while not flushed/stalled.
//   - Cleared only by reset.
// ID_EX_ILLEGAL_TRAP_EN undefined: port absent; illegal opcodes silently bubbled (not counted).
// TESTING
// 1. Reset 2 cycles with random inputs -> all *_o 0, pc_write_o=1, bubble_cnt_o=0.
// 2. add x3,x1,x2 (opcode 0110011, regwrite=1, aluop=10) -> next cycle regwrite_o=1, aluop_o=2'b10, rd_o=3.
// 3. lw x5 in EX then add x6,x5,x1 in ID -> pc_write_o=0 one cycle, bubble, bubble_cnt_o=1; add lands next cycle.
// 4. lw x0 then add using x0 -> no stall, bubble_cnt_o unchanged.
// 5. flush_i=1 with hazard active -> one bubble, pc_write_o=1, bubble_cnt_o+1.
// 6. CNT_W=2, five bubbles -> count 3 held; opcode 1111111 -> controls 0, illegal_o=1 if ID_EX_ILLEGAL_TRAP_EN.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbling and a saturating bubble counter.
// Optional sticky illegal-opcode flag is enabled by defining ID_EX_ILLEGAL_TRAP_EN.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic [6:0]       opcode_i,
  input  logic             alusrc_i,
  input  logic [1:0]       mem2reg_i,
  input  logic             regwrite_i,
  input  logic             memread_i,
  input  logic             memwrite_i,
  input  logic [1:0]       branch_i,
  input  logic [1:0]       aluop_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [4:0]       rd_i,
  input  logic [3:0]       funct_i,
  output logic [6:0]       opcode_o,
  output logic             alusrc_o,
  output logic [1:0]       mem2reg_o,
  output logic             regwrite_o,
  output logic             memread_o,
  output logic             memwrite_o,
  output logic [1:0]       branch_o,
  output logic [1:0]       aluop_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rd_o,
  output logic [3:0]       funct_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic [CNT_W-1:0] bubble_cnt_o
`ifdef ID_EX_ILLEGAL_TRAP_EN
  ,
  output logic             illegal_o
`endif
);

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b0010011, 7'b1100111, 7'b1101111: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  // Unknown control bits collapse to 0 in simulation; synthesis sees a plain pass-through.
  function automatic logic clean1(input logic v);
    clean1 = (v === 1'b1) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [1:0] clean2(input logic [1:0] v);
    clean2 = (^v === 1'bx) ? 2'b00 : v;
  endfunction

  logic hazard;
  logic stall;
  logic legal;
  logic bubble;
  logic count_en;

  assign hazard = memread_o & (rd_o != 5'd0) & ((rd_o == rs1_i) | (rd_o == rs2_i));
  assign stall = hazard & ~flush_i & ~reset;
  assign pc_write_o = ~stall;
  assign ifid_write_o = ~stall;
  assign legal = is_legal(opcode_i);
  assign count_en = flush_i | stall;
  assign bubble = reset | count_en | ~legal;

  // Pipeline register: reset, flush, stall and illegal opcodes all load an all-zero bubble.
  always_ff @(posedge clk) begin
    if (bubble) begin
      opcode_o   <= 7'd0;
      alusrc_o   <= 1'b0;
      mem2reg_o  <= 2'b00;
      regwrite_o <= 1'b0;
      memread_o  <= 1'b0;
      memwrite_o <= 1'b0;
      branch_o   <= 2'b00;
      aluop_o    <= 2'b00;
      pc_o       <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      rs1_o      <= 5'd0;
      rs2_o      <= 5'd0;
      rd_o       <= 5'd0;
      funct_o    <= 4'd0;
    end else begin
      opcode_o   <= opcode_i;
      alusrc_o   <= clean1(alusrc_i);
      mem2reg_o  <= clean2(mem2reg_i);
      regwrite_o <= clean1(regwrite_i);
      memread_o  <= clean1(memread_i);
      memwrite_o <= clean1(memwrite_i);
      branch_o   <= clean2(branch_i);
      aluop_o    <= clean2(aluop_i);
      pc_o       <= pc_i;
      rs1_data_o <= rs1_data_i;
      rs2_data_o <= rs2_data_i;
      imm_o      <= imm_i;
      rs1_o      <= rs1_i;
      rs2_o      <= rs2_i;
      rd_o       <= rd_i;
      funct_o    <= funct_i;
    end
  end

  // Bubble counter: only flush/stall bubbles count, and it sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_o <= '0;
    end else if (count_en && (bubble_cnt_o != {CNT_W{1'b1}})) begin
      bubble_cnt_o <= bubble_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt_o <= bubble_cnt_o;
    end
  end

`ifdef ID_EX_ILLEGAL_TRAP_EN
  // Sticky flag set only when the illegal instruction would otherwise have been captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_o <= 1'b0;
    end else if (!count_en && !legal) begin
      illegal_o <= 1'b1;
    end else begin
      illegal_o <= illegal_o;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; a second instance with CNT_W=2 covers counter saturation.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_ADD = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_NOP = 7'b0010011;

  logic clk = 1'b0;
  logic reset, flush_i, alusrc_i, regwrite_i, memread_i, memwrite_i;
  logic [6:0] opcode_i;
  logic [1:0] mem2reg_i, branch_i, aluop_i;
  logic [XLEN-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [4:0] rs1_i, rs2_i, rd_i;
  logic [3:0] funct_i;

  logic [6:0] opcode_o, d2_opcode;
  logic alusrc_o, regwrite_o, memread_o, memwrite_o, pc_write_o, ifid_write_o;
  logic d2_alusrc, d2_regwrite, d2_memread, d2_memwrite, d2_pc_write, d2_ifid_write;
  logic [1:0] mem2reg_o, branch_o, aluop_o, d2_mem2reg, d2_branch, d2_aluop;
  logic [XLEN-1:0] pc_o, rs1_data_o, rs2_data_o, imm_o, d2_pc, d2_rs1_data, d2_rs2_data, d2_imm;
  logic [4:0] rs1_o, rs2_o, rd_o, d2_rs1, d2_rs2, d2_rd;
  logic [3:0] funct_o, d2_funct;
  logic [15:0] bubble_cnt_o;
  logic [1:0] d2_cnt;
`ifdef ID_EX_ILLEGAL_TRAP_EN
  logic illegal_o, d2_illegal;
`endif

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  wire [163:0] all_o = {opcode_o, alusrc_o, mem2reg_o, regwrite_o, memread_o, memwrite_o,
                        branch_o, aluop_o, pc_o, rs1_data_o, rs2_data_o, imm_o,
                        rs1_o, rs2_o, rd_o, funct_o};

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .opcode_i(opcode_i), .alusrc_i(alusrc_i),
    .mem2reg_i(mem2reg_i), .regwrite_i(regwrite_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .branch_i(branch_i), .aluop_i(aluop_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .imm_i(imm_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .funct_i(funct_i), .opcode_o(opcode_o), .alusrc_o(alusrc_o), .mem2reg_o(mem2reg_o),
    .regwrite_o(regwrite_o), .memread_o(memread_o), .memwrite_o(memwrite_o), .branch_o(branch_o),
    .aluop_o(aluop_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .funct_o(funct_o),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .bubble_cnt_o(bubble_cnt_o)
`ifdef ID_EX_ILLEGAL_TRAP_EN
    , .illegal_o(illegal_o)
`endif
  );

  id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .flush_i(flush_i), .opcode_i(opcode_i), .alusrc_i(alusrc_i),
    .mem2reg_i(mem2reg_i), .regwrite_i(regwrite_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .branch_i(branch_i), .aluop_i(aluop_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .imm_i(imm_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .funct_i(funct_i), .opcode_o(d2_opcode), .alusrc_o(d2_alusrc), .mem2reg_o(d2_mem2reg),
    .regwrite_o(d2_regwrite), .memread_o(d2_memread), .memwrite_o(d2_memwrite), .branch_o(d2_branch),
    .aluop_o(d2_aluop), .pc_o(d2_pc), .rs1_data_o(d2_rs1_data), .rs2_data_o(d2_rs2_data),
    .imm_o(d2_imm), .rs1_o(d2_rs1), .rs2_o(d2_rs2), .rd_o(d2_rd), .funct_o(d2_funct),
    .pc_write_o(d2_pc_write), .ifid_write_o(d2_ifid_write), .bubble_cnt_o(d2_cnt)
`ifdef ID_EX_ILLEGAL_TRAP_EN
    , .illegal_o(d2_illegal)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic mr, input logic mw, input logic rw,
                           input logic [1:0] aop);
    opcode_i = op; rs1_i = rs1; rs2_i = rs2; rd_i = rd;
    memread_i = mr; memwrite_i = mw; regwrite_i = rw; aluop_i = aop;
    alusrc_i = 1'b0; mem2reg_i = 2'b00; branch_i = 2'b00; funct_i = 4'd0;
    pc_i = 32'h0; rs1_data_i = 32'h0; rs2_data_i = 32'h0; imm_i = 32'h0;
  endtask

  task automatic test_reset();
    flush_i = 1'b0;
    set_instr(OP_LW, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 2'($urandom));
    pc_i = $urandom; rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom;
    funct_i = 4'($urandom); mem2reg_i = 2'($urandom); branch_i = 2'($urandom);
    reset = 1'b1;
    step(); step();
    checks++; if (all_o !== 164'd0) begin failures++; $display("FAIL reset_outs got=%h exp=0", all_o); end
    checks++; if (pc_write_o !== 1'b1) begin failures++; $display("FAIL reset_pc_write got=%b exp=1", pc_write_o); end
    checks++; if (ifid_write_o !== 1'b1) begin failures++; $display("FAIL reset_ifid_write got=%b exp=1", ifid_write_o); end
    checks++; if (bubble_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt_o); end
    checks++; if (d2_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt2 got=%0d exp=0", d2_cnt); end
`ifdef ID_EX_ILLEGAL_TRAP_EN
    checks++; if (illegal_o !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal_o); end
`endif
    set_instr(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    reset = 1'b0;
    step();
    exp_cnt = 0;
  endtask

  task automatic test_alu();
    set_instr(OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 2'b10);
    pc_i = 32'h40; rs1_data_i = 32'd100; rs2_data_i = 32'd200; funct_i = 4'b1000;
    step();
    checks++; if (regwrite_o !== 1'b1) begin failures++; $display("FAIL alu_regwrite got=%b exp=1", regwrite_o); end
    checks++; if (aluop_o !== 2'b10) begin failures++; $display("FAIL alu_aluop got=%b exp=10", aluop_o); end
    checks++; if (rd_o !== 5'd3) begin failures++; $display("FAIL alu_rd got=%0d exp=3", rd_o); end
    checks++; if ({pc_o, rs1_data_o, rs2_data_o, funct_o} !== {32'h40, 32'd100, 32'd200, 4'b1000}) begin
      failures++; $display("FAIL alu_data got=%h/%0d/%0d/%b exp=40/100/200/1000", pc_o, rs1_data_o, rs2_data_o, funct_o);
    end
  endtask

  task automatic test_load_use();
    set_instr(OP_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 2'b00);
    alusrc_i = 1'b1; mem2reg_i = 2'b01;
    step();
    checks++; if (memread_o !== 1'b1 || rd_o !== 5'd5) begin failures++; $display("FAIL lu_lw got=%b/%0d exp=1/5", memread_o, rd_o); end
    set_instr(OP_ADD, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0, 1'b1, 2'b10);
    #1;
    checks++; if ({pc_write_o, ifid_write_o} !== 2'b00) begin failures++; $display("FAIL lu_stall got=%b exp=00", {pc_write_o, ifid_write_o}); end
    step(); exp_cnt++;
    checks++; if ({regwrite_o, memread_o, rd_o} !== 7'd0) begin failures++; $display("FAIL lu_bubble got=%b/%b/%0d exp=0/0/0", regwrite_o, memread_o, rd_o); end
    checks++; if (bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL lu_cnt got=%0d exp=%0d", bubble_cnt_o, exp_cnt); end
    checks++; if (pc_write_o !== 1'b1) begin failures++; $display("FAIL lu_release got=%b exp=1", pc_write_o); end
    step();
    checks++; if (regwrite_o !== 1'b1 || rd_o !== 5'd6) begin failures++; $display("FAIL lu_add_lands got=%b/%0d exp=1/6", regwrite_o, rd_o); end
    set_instr(OP_LW, 5'd2, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    set_instr(OP_SW, 5'd3, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00);
    #1;
    checks++; if (pc_write_o !== 1'b0) begin failures++; $display("FAIL lu_rs2_stall got=%b exp=0", pc_write_o); end
    step(); exp_cnt++;
    checks++; if (memwrite_o !== 1'b0) begin failures++; $display("FAIL lu_rs2_bubble got=%b exp=0", memwrite_o); end
    checks++; if (d2_cnt !== 2'd2) begin failures++; $display("FAIL lu_cnt2 got=%0d exp=2", d2_cnt); end
    step();
    checks++; if (memwrite_o !== 1'b1 || rs2_o !== 5'd9) begin failures++; $display("FAIL lu_sw_lands got=%b/%0d exp=1/9", memwrite_o, rs2_o); end
  endtask

  task automatic test_x0();
    set_instr(OP_LW, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    set_instr(OP_ADD, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 2'b10);
    #1;
    checks++; if (pc_write_o !== 1'b1) begin failures++; $display("FAIL x0_nostall got=%b exp=1", pc_write_o); end
    step();
    checks++; if (rd_o !== 5'd7 || bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL x0_capture got=%0d/%0d exp=7/%0d", rd_o, bubble_cnt_o, exp_cnt); end
  endtask

  task automatic test_flush();
    set_instr(OP_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    set_instr(OP_ADD, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0, 1'b1, 2'b10);
    flush_i = 1'b1;
    #1;
    checks++; if ({pc_write_o, ifid_write_o} !== 2'b11) begin failures++; $display("FAIL fl_nostall got=%b exp=11", {pc_write_o, ifid_write_o}); end
    step(); exp_cnt++;
    checks++; if (regwrite_o !== 1'b0 || rd_o !== 5'd0) begin failures++; $display("FAIL fl_bubble got=%b/%0d exp=0/0", regwrite_o, rd_o); end
    checks++; if (bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL fl_cnt got=%0d exp=%0d", bubble_cnt_o, exp_cnt); end
    step(); exp_cnt++;
    checks++; if (bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL fl_cnt_plain got=%0d exp=%0d", bubble_cnt_o, exp_cnt); end
    flush_i = 1'b0;
    step();
    checks++; if (regwrite_o !== 1'b1 || rd_o !== 5'd6) begin failures++; $display("FAIL fl_resume got=%b/%0d exp=1/6", regwrite_o, rd_o); end
  endtask

  task automatic test_illegal();
    set_instr(7'b1111111, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 2'b10);
    step();
    checks++; if ({regwrite_o, memwrite_o, memread_o, aluop_o} !== 5'd0) begin
      failures++; $display("FAIL ill_controls got=%b%b%b%b exp=00000", regwrite_o, memwrite_o, memread_o, aluop_o);
    end
    checks++; if (bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL ill_cnt got=%0d exp=%0d", bubble_cnt_o, exp_cnt); end
`ifdef ID_EX_ILLEGAL_TRAP_EN
    checks++; if (illegal_o !== 1'b1) begin failures++; $display("FAIL ill_flag got=%b exp=1", illegal_o); end
`endif
    set_instr(OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 2'b10);
    step();
    checks++; if (regwrite_o !== 1'b1) begin failures++; $display("FAIL ill_recover got=%b exp=1", regwrite_o); end
`ifdef ID_EX_ILLEGAL_TRAP_EN
    checks++; if (illegal_o !== 1'b1) begin failures++; $display("FAIL ill_sticky got=%b exp=1", illegal_o); end
`endif
  endtask

  task automatic test_saturation();
    flush_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); exp_cnt++;
    end
    flush_i = 1'b0;
    checks++; if (d2_cnt !== 2'b11) begin failures++; $display("FAIL sat_cnt2 got=%0d exp=3", d2_cnt); end
    checks++; if (bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL sat_cnt16 got=%0d exp=%0d", bubble_cnt_o, exp_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    set_instr(OP_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    set_instr(OP_ADD, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0, 1'b1, 2'b10);
    #1;
    checks++; if (pc_write_o !== 1'b0) begin failures++; $display("FAIL rs_stall got=%b exp=0", pc_write_o); end
    reset = 1'b1;
    #1;
    checks++; if (pc_write_o !== 1'b1) begin failures++; $display("FAIL rs_override got=%b exp=1", pc_write_o); end
    step();
    reset = 1'b0; exp_cnt = 0;
    checks++; if (all_o !== 164'd0) begin failures++; $display("FAIL rs_empty got=%h exp=0", all_o); end
    checks++; if (bubble_cnt_o !== 16'd0 || d2_cnt !== 2'd0) begin failures++; $display("FAIL rs_cnt got=%0d/%0d exp=0/0", bubble_cnt_o, d2_cnt); end
`ifdef ID_EX_ILLEGAL_TRAP_EN
    checks++; if (illegal_o !== 1'b0) begin failures++; $display("FAIL rs_illegal got=%b exp=0", illegal_o); end
`endif
    #1;
    checks++; if (pc_write_o !== 1'b1) begin failures++; $display("FAIL rs_release got=%b exp=1", pc_write_o); end
    step();
    checks++; if (rd_o !== 5'd6 || bubble_cnt_o !== 16'd0) begin failures++; $display("FAIL rs_capture got=%0d/%0d exp=6/0", rd_o, bubble_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_use();
    test_x0();
    test_flush();
    test_illegal();
    test_saturation();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
